// File: rtl/mem_arb_pkg.sv
// Shared definitions for the slowmem arbiter: FSM encoding, requester
// indices, word width and the data word returned on a read timeout.
package mem_arb_pkg;

  localparam int WORD = 16;

  localparam logic [WORD-1:0] ERR_RDATA = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] REQ_IF0 = 2'd0;
  localparam logic [1:0] REQ_IF1 = 2'd1;
  localparam logic [1:0] REQ_D0  = 2'd2;
  localparam logic [1:0] REQ_D1  = 2'd3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker for one requester class (PID0/PID1).
// A lone requester wins outright; on a tie the pointer selects the winner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       any
);

  // One-hot grant: pass a single request through, break ties with ptr.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  assign any = |req;

endmodule

// File: rtl/slowmem_arbiter.sv
// Four-way arbiter in front of the single-outstanding slowmem port.
// Requesters: IF PID0/PID1 (req[1:0]) and DATA PID0/PID1 (req[3:2]).
// Optional read watchdog enabled by defining ARB_TIMEOUT_EN.
//
// Handshake: requester i raises req[i] with rnotw/addr/wdata stable and
// holds them until it sees the one-cycle done[i]; keeping req[i] high
// issues another request. req is only sampled while the FSM is IDLE.
module slowmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = WORD,
  parameter int DATA_W  = WORD,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          req_rnotw,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy,
  output logic                mem_strobe,
  output logic                mem_rnotw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_mfc,
  input  logic [DATA_W-1:0]   mem_rdata,
  output state_t              dbg_state
);

  // A zero limit would leave the watchdog no cycle to count.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("slowmem_arbiter: TIMEOUT must be at least 1");
  end

  state_t            state, state_n;
  logic [1:0]        owner, owner_n, win;
  logic              ptr_if, ptr_if_n, ptr_d, ptr_d_n;
  logic [1:0]        gnt_if, gnt_d;
  logic              any_if, any_d;
  logic [3:0]        done_n;
  logic [DATA_W-1:0] rdata_n, wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic              err_n, strobe_n, rnotw_n;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
`endif

  rr_pick2 u_pick_if (.req(req[1:0]), .ptr(ptr_if), .gnt(gnt_if), .any(any_if));
  rr_pick2 u_pick_d  (.req(req[3:2]), .ptr(ptr_d),  .gnt(gnt_d),  .any(any_d));

  // Data class always beats instruction fetch.
  assign win = any_d ? (gnt_d[1]  ? REQ_D1  : REQ_D0)
                     : (gnt_if[1] ? REQ_IF1 : REQ_IF0);

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Next-state and next-output logic; every registered output has a default.
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    ptr_if_n = ptr_if;
    ptr_d_n  = ptr_d;
    done_n   = 4'b0000;
    err_n    = 1'b0;
    rdata_n  = rdata;
    strobe_n = 1'b0;
    rnotw_n  = mem_rnotw;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
`ifdef ARB_TIMEOUT_EN
    wd_cnt_n = wd_cnt;
`endif
    case (state)
      IDLE: begin
        if (any_d || any_if) begin
          owner_n  = win;
          strobe_n = 1'b1;
          rnotw_n  = req_rnotw[win];
          addr_n   = req_addr[win*ADDR_W +: ADDR_W];
          wdata_n  = req_wdata[win*DATA_W +: DATA_W];
          // Point the granted class at the PID that did not just win.
          if (any_d) ptr_d_n  = ~win[0];
          else       ptr_if_n = ~win[0];
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rnotw) begin
          state_n  = RD_WAIT;
`ifdef ARB_TIMEOUT_EN
          wd_cnt_n = '0;
`endif
        end else begin
          done_n[owner] = 1'b1;
          state_n       = IDLE;
        end
      end
      RD_WAIT: begin
        if (mem_mfc) begin
          rdata_n       = mem_rdata;
          done_n[owner] = 1'b1;
          state_n       = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
          rdata_n       = DATA_W'(ERR_RDATA);
          err_n         = 1'b1;
          done_n[owner] = 1'b1;
          state_n       = IDLE;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= REQ_IF0;
      ptr_if     <= 1'b0;
      ptr_d      <= 1'b0;
      done       <= 4'b0000;
      rdata      <= '0;
      err        <= 1'b0;
      mem_strobe <= 1'b0;
      mem_rnotw  <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      ptr_if     <= ptr_if_n;
      ptr_d      <= ptr_d_n;
      done       <= done_n;
      rdata      <= rdata_n;
      err        <= err_n;
      mem_strobe <= strobe_n;
      mem_rnotw  <= rnotw_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
`ifdef ARB_TIMEOUT_EN
      wd_cnt     <= wd_cnt_n;
`endif
    end
  end

endmodule
